// File: rtl/rt_seq_pkg.sv
// Shared types and constants for the raster pixel sequencer.
// Holds the FSM state type, default parameters and the credit-counter width helper.
// No logic; imported by the sequencer top and its result FIFO.
package rt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } seq_state_t;

    localparam int DEF_IW         = 16;
    localparam int DEF_QW         = 16;
    localparam int DEF_DW         = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    // Wide enough to hold the values 0..depth inclusive.
    function automatic int inflight_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rt_stream_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush.
// Latency: a push is visible on out_valid/out_data the following cycle.
// Backpressure: pop only acts when out_valid; a push into a full FIFO is dropped unless a pop frees the slot that cycle.
module rt_stream_fifo
    import rt_seq_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    // Storage is never reset, so the head word is gated to zero while empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_pop    = pop & out_valid;
    assign do_push   = push & (~full | do_pop);

    // Write the incoming word into the tail slot; a flush discards it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rt_pixel_sequencer.sv
// Raster-order pixel issuer feeding a fixed-latency shading pipeline, results drained as a valid/ready fragment stream.
// Latency: first issue one cycle after start; a pipeline result appears on m_valid the cycle after it arrives.
// Backpressure: issue stalls while inflight + buffered results reach FIFO_DEPTH, so no result is ever dropped.
module rt_pixel_sequencer
    import rt_seq_pkg::*;
#(
    parameter int IW         = DEF_IW,
    parameter int QW         = DEF_QW,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [IW-1:0]    image_width,
    input  logic [IW-1:0]    image_height,
    output logic             issue_valid,
    output logic [IW+QW-1:0] issue_x,
    output logic [IW+QW-1:0] issue_y,
    input  logic             result_valid,
    input  logic [DW-1:0]    result_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = inflight_w(FIFO_DEPTH);
    localparam int TW = 2 * IW;

    seq_state_t    state;
    logic [IW-1:0] w_q, h_q, x_q, y_q;
    logic [TW-1:0] total_q, out_cnt;
    logic [CW-1:0] inflight, inflight_nxt, fifo_count;
    logic          fifo_vld, fifo_full;
    logic [DW-1:0] fifo_dat;

    logic          start_go, zero_size, credit_ok, issue_go, flush_go;
    logic          res_ok, fifo_push, pop, err_set, row_end, frame_end;
    logic [IW-1:0] cur_x, cur_y, cur_w, cur_h;

    // In IDLE the next pixel is (0,0) of the frame being started, sized from the live inputs.
    assign cur_x     = (state == IDLE) ? '0 : x_q;
    assign cur_y     = (state == IDLE) ? '0 : y_q;
    assign cur_w     = (state == IDLE) ? image_width  : w_q;
    assign cur_h     = (state == IDLE) ? image_height : h_q;
    assign row_end   = (cur_x == cur_w - IW'(1));
    assign frame_end = row_end && (cur_y == cur_h - IW'(1));

    assign start_go  = (state == IDLE) && start;
    assign zero_size = (image_width == '0) || (image_height == '0);
    // Credits use this cycle's values only; a result or pop now frees a slot next cycle.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign issue_go  = credit_ok && ((start_go && !zero_size) || ((state == RUN) && !abort));
    assign flush_go  = abort && ((state == RUN) || (state == DRAIN));

    // Results with nothing outstanding are protocol errors and never enter the FIFO.
    assign res_ok    = result_valid && (inflight != '0);
    assign fifo_push = res_ok && (state != FLUSH) && !flush_go;
    assign pop       = fifo_vld && m_ready;
    assign err_set   = (result_valid && (inflight == '0)) || (fifo_push && fifo_full && !pop);

    assign inflight_nxt = inflight + CW'(issue_go) - CW'(res_ok);

    assign m_valid = fifo_vld;
    assign m_data  = fifo_dat;
    assign m_last  = fifo_vld && (out_cnt == total_q - TW'(1));
    assign busy    = (state != IDLE);

    rt_stream_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush_go),
        .push      (fifo_push),
        .push_data (result_data),
        .pop       (pop),
        .out_valid (fifo_vld),
        .out_data  (fifo_dat),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Frame FSM with registered issue outputs, credit counter, beat counter and status flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            total_q     <= '0;
            out_cnt     <= '0;
            inflight    <= '0;
            issue_valid <= 1'b0;
            issue_x     <= '0;
            issue_y     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight_nxt;
            if (err_set) err <= 1'b1;
            if (pop) out_cnt <= out_cnt + TW'(1);

            issue_valid <= issue_go;
            if (issue_go) begin
                issue_x <= {cur_x, {QW{1'b0}}};
                issue_y <= {cur_y, {QW{1'b0}}};
                if (row_end) begin
                    x_q <= '0;
                    y_q <= cur_y + IW'(1);
                end else begin
                    x_q <= cur_x + IW'(1);
                    y_q <= cur_y;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        w_q     <= image_width;
                        h_q     <= image_height;
                        total_q <= TW'(image_width) * TW'(image_height);
                        out_cnt <= '0;
                        if (zero_size)      done  <= 1'b1;
                        else if (frame_end) state <= DRAIN;
                        else                state <= RUN;
                    end
                end
                RUN: begin
                    if (abort)                      state <= FLUSH;
                    else if (issue_go && frame_end) state <= DRAIN;
                end
                DRAIN: begin
                    if (abort) begin
                        state <= FLUSH;
                    end else if (pop && m_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (inflight_nxt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_pixel_sequencer.sv
module tb_rt_pixel_sequencer;
    localparam int IW = 16;
    localparam int QW = 16;
    localparam int DW = 32;
    localparam int FD = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             abort;
    logic [IW-1:0]    image_width;
    logic [IW-1:0]    image_height;
    logic             issue_valid;
    logic [IW+QW-1:0] issue_x;
    logic [IW+QW-1:0] issue_y;
    logic             result_valid;
    logic [DW-1:0]    result_data;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // pipeline model state (owned by the pipeline process)
    int          pq_due[$];
    logic [31:0] pq_dat[$];
    logic        pipe_rv;
    logic [31:0] pipe_rd;
    int          n_issued = 0;
    int          lat = 3;

    // spurious-result injection (owned by the main sequence)
    logic spur_rv;

    // expected fragment list: written by main, consumed by the monitor
    logic [31:0] exp_mem [256];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          n_popped = 0;
    int          last_hs_cyc = -100;
    int          cred_adj = 0;
    int          iss_base = 0;
    int          start_cyc = 0;
    int          rmode = 0;

    assign result_valid = pipe_rv | spur_rv;
    assign result_data  = pipe_rd;

    rt_pixel_sequencer #(
        .IW(IW), .QW(QW), .DW(DW), .FIFO_DEPTH(FD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .image_width  (image_width),
        .image_height (image_height),
        .issue_valid  (issue_valid),
        .issue_x      (issue_x),
        .issue_y      (issue_y),
        .result_valid (result_valid),
        .result_data  (result_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Shading pipeline: fixed latency, in order, result = {y, x}.
    initial begin
        pipe_rv = 1'b0;
        pipe_rd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (issue_valid === 1'b1) begin
                check("issue_frac_zero", 64'(issue_x[QW-1:0] | issue_y[QW-1:0]), 64'd0);
                pq_due.push_back(cyc + lat);
                pq_dat.push_back({issue_y[QW +: 16], issue_x[QW +: 16]});
                n_issued++;
            end
            if (pq_due.size() > 0 && pq_due[0] == cyc) begin
                pipe_rv = 1'b1;
                pipe_rd = pq_dat.pop_front();
                void'(pq_due.pop_front());
            end else begin
                pipe_rv = 1'b0;
            end
        end
    end

    // Consumer ready generator.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Stream monitor / scoreboard, sampled on the falling edge.
    initial begin
        logic        stall_prev;
        logic [31:0] prev_dat;
        logic        prev_last;
        logic [63:0] e;
        stall_prev = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (stall_prev) begin
                    check("stall_valid_held", 64'(m_valid), 64'd1);
                    check("stall_data_stable", 64'(m_data), 64'(prev_dat));
                    check("stall_last_stable", 64'(m_last), 64'(prev_last));
                end
                if (busy === 1'b1)
                    check("credit_limit", 64'((n_issued - n_popped - cred_adj) <= FD), 64'd1);
                if (m_valid && m_ready) begin
                    if (exp_rd != exp_wr) begin
                        e = {32'h0, exp_mem[exp_rd % 256]};
                        exp_rd++;
                    end else begin
                        e = 64'hFFFF_FFFF_FFFF_FFFF;
                    end
                    check("frag_data", {32'h0, m_data}, e);
                    check("frag_last", 64'(m_last), 64'(exp_rd == exp_wr));
                    n_popped++;
                    if (m_last) last_hs_cyc = cyc;
                end
                if (abort && busy) exp_rd = exp_wr;
                stall_prev = m_valid && !m_ready && !abort;
                prev_dat   = m_data;
                prev_last  = m_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic begin_frame(input int w, input int h, input int l, input int mode);
        lat      = l;
        rmode    = mode;
        cred_adj = n_issued - n_popped;
        iss_base = n_issued;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                exp_mem[exp_wr % 256] = {yy[15:0], xx[15:0]};
                exp_wr++;
            end
        end
        start_cyc    = cyc;
        image_width  = w[IW-1:0];
        image_height = h[IW-1:0];
        start        = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_issue_valid", 64'(issue_valid), 64'd1);
        check("start_issue_x", 64'(issue_x), 64'd0);
        check("start_issue_y", 64'(issue_y), 64'd0);
        check("done_pulse_width", 64'(done), 64'd0);
    endtask

    task automatic end_frame(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        check("done_within_budget", 64'(dcyc >= 0), 64'd1);
        check("done_after_last_beat", 64'(dcyc), 64'(last_hs_cyc + 1));
        check("frags_outstanding", 64'(exp_wr - exp_rd), 64'd0);
        check("frame_err", 64'(err), 64'd0);
        check("frame_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int dcyc;
        int found;
        int exited;
        resetn       = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        spur_rv      = 1'b0;
        image_width  = '0;
        image_height = '0;
        repeat (3) step();

        // reset state
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_x", 64'(issue_x), 64'd0);
        check("rst_issue_y", 64'(issue_y), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        resetn = 1'b1;
        step();

        // 4x2, latency 3, always ready: last beat at cycle 12, done at 13
        begin_frame(4, 2, 3, 0);
        end_frame(100, dcyc);
        check("a_done_cycle", 64'(dcyc - start_cyc), 64'd13);

        // back-to-back 3x3 with 1-0-0-1 backpressure
        begin_frame(3, 3, 3, 1);
        end_frame(200, dcyc);

        // long latency with consumer stalled: exactly FD issues then stall
        begin_frame(5, 5, 12, 3);
        repeat (19) step();
        check("longlat_issue_count", 64'(n_issued - iss_base), 64'(FD));
        check("longlat_issue_stalled", 64'(issue_valid), 64'd0);
        check("longlat_err", 64'(err), 64'd0);
        rmode = 0;
        end_frame(300, dcyc);

        // zero-size frame
        image_width  = 16'd0;
        image_height = 16'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_issue", 64'(issue_valid), 64'd0);
        check("zero_m_valid", 64'(m_valid), 64'd0);
        step();
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_m_valid2", 64'(m_valid), 64'd0);

        // abort in RUN with 5 results still in the pipeline
        begin_frame(6, 4, 8, 3);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pq_due.size() == 5 && m_valid) begin
                found = 1;
                break;
            end
        end
        check("abort_setup", 64'(found), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_m_valid_low", 64'(m_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        exited = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("flush_no_done", 64'(done), 64'd0);
            check("flush_m_valid", 64'(m_valid), 64'd0);
            if (!pipe_rv && pq_due.size() == 0) begin
                check("flush_exit_idle", 64'(busy), 64'd0);
                exited = 1;
                break;
            end
            check("flush_busy", 64'(busy), 64'd1);
        end
        check("flush_bounded", 64'(exited), 64'd1);
        check("abort_err", 64'(err), 64'd0);

        // normal frame after abort
        begin_frame(2, 2, 3, 0);
        end_frame(100, dcyc);

        // randomized frames
        for (int k = 0; k < 4; k++) begin
            begin_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                        int'($urandom_range(1, 10)), 2);
            end_frame(600, dcyc);
        end

        // spurious result in IDLE sets a sticky error
        step();
        check("err_before_spur", 64'(err), 64'd0);
        spur_rv = 1'b1;
        step();
        spur_rv = 1'b0;
        check("err_set", 64'(err), 64'd1);
        check("spur_no_frag", 64'(m_valid), 64'd0);
        repeat (5) step();
        check("err_sticky", 64'(err), 64'd1);
        resetn = 1'b0;
        step();
        check("err_cleared_by_reset", 64'(err), 64'd0);
        resetn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
